req_array_selector: RTL and testbench
=====================================

// Module: req_array_selector
// PURPOSE
//  Steers each incoming bank request into one of ARR_NUM_RD read arrays or ARR_NUM_WR write arrays.
//  Successor of the bank-scheduler selector, with these additions:
//  - occupancy, last row address and row-hit valid flag tracked internally per array;
//  - valid/ready backpressure toward the front end;
//  - round-robin tie-break inside each priority tier;
//  - registered one-hot push plus push address toward the arrays.
// PARAMETERS
//  RA_BITS    8  row-address width compared for row hits
//  ARR_NUM_RD 4  read arrays, indices 0..ARR_NUM_RD-1 (>=1)
//  ARR_NUM_WR 3  write arrays, indices ARR_NUM_RD..N-1 (>=1); N=ARR_NUM_RD+ARR_NUM_WR
//  DEPTH      8  entries per array (>=2); CNT_W=$clog2(DEPTH+1)
//  MID_LEVEL  4  "almost empty" threshold, 1..DEPTH
//  READ       0  in_type encoding for read
//  WRITE      1  in_type encoding for write
// PORTS
//  clk       in   1          clock, all logic on rising edge
//  rst       in   1          synchronous reset, active-high
//  in_valid  in   1          request present
//  in_ready  out  1          selector can accept (accept = in_valid & in_ready)
//  in_type   in   1          READ/WRITE
//  in_addr   in   RA_BITS    request row address
//  pop       in   N          array i dequeued one entry this cycle
//  push      out  N          registered one-hot array write enable
//  push_addr out  RA_BITS    registered row address of pushed request
//  occ       out  N*CNT_W    occupancy of array i at [i*CNT_W +: CNT_W]
//  err       out  1          sticky protocol error
// BEHAVIOUR
//  Reset: cnt[]=0, last_vld[]=0, last_addr[]=0, rr_rd=0, rr_wr=ARR_NUM_RD, push=0, push_addr=0, err=0.
//  Candidate group: arrays of in_type only. Reads never go to write arrays, and writes never go to read arrays.
//  Tiers, evaluated in order; the first non-empty tier wins:
//   T1 row hit: last_vld[i] & last_addr[i]==in_addr & cnt[i]<DEPTH
//   T2 empty: cnt[i]==0
//   T3 below mid: cnt[i]<MID_LEVEL
//   T4 not full: cnt[i]<DEPTH
//  Within a tier, pick the first candidate at or after the group rr pointer, wrapping within the group.
//  in_ready is combinational: 1 iff the T4 set of in_type is non-empty. It is valid only while in_valid=1 and is 0 during rst.
//  On the accept edge:
//   - cnt[sel]+1 (reservation counting);
//   - last_addr[sel]=in_addr and last_vld[sel]=1;
//   - rr pointer of that group = sel+1, wrapping to the group base;
//   - push<=onehot(sel) and push_addr<=in_addr.
//  Latency: push is asserted exactly 1 cycle after accept, for exactly 1 cycle. push=0 in cycles with no accept, and push_addr holds its value.
//  No downstream backpressure. Space is guaranteed by cnt, which includes requests accepted but not yet written.
//  pop[i] decrements cnt[i]. If accept-to-i and pop[i] occur in the same cycle, cnt[i] is unchanged.
//  pop[i] with cnt[i]==0 and no accept-to-i: cnt[i] stays 0 and err<=1; err stays set until rst.
//  When cnt[i] reaches 0 through a pop, last_vld[i]<=0 (no hit on a drained array). An accept to i in the same cycle keeps last_vld[i]=1.
//  Selection uses pre-edge cnt. A pop in the same cycle does not make a full array eligible until the next cycle.
//  Back-to-back accepts are supported every cycle.
//  rst mid-operation: a pending push is dropped (push=0 in the cycle after rst), and all state returns to reset values.
//  occ is the registered cnt. It is never greater than DEPTH.
// TESTING
//  1 After rst, READ 0x12 valid -> in_ready=1; next cycle push=7'b0000001, push_addr=0x12; occ0=1; rr_rd=1.
//  2 Then READ 0x12 -> T1 hit, push[0], occ0=2; then READ 0x34 -> T2, push[1]; then READ 0x56 -> T2, push[2].
//  3 After rst, WRITE 0xAA -> push[4]; WRITE 0xBB -> push[5]; WRITE 0xAA -> hit, push[4]; no read array changes.
//  4 Fill read arrays 0..3 to 8 with no pops -> READ in_ready=0 while WRITE in_ready=1; pop[2] -> next cycle READ accepted into array 2.
//  5 occ3=3, accept-to-3 and pop[3] in the same cycle -> occ3 stays 3; pop[1] with occ1=0 -> err=1, occ1=0.
//  6 rst asserted in the cycle after an accept -> push=0, all occ=0, err=0, in_ready=0 while rst=1.

Source files
------------

// File: rtl/req_array_selector.sv
// Steers each accepted bank request into a read or write array by row-hit / empty / below-mid /
// not-full priority with per-group round-robin; tracks per-array occupancy and emits a registered push.
module req_array_selector #(
   parameter int RA_BITS    = 8,
   parameter int ARR_NUM_RD = 4,
   parameter int ARR_NUM_WR = 3,
   parameter int DEPTH      = 8,
   parameter int MID_LEVEL  = 4,
   parameter int READ       = 0,
   parameter int WRITE      = 1,
   localparam int N         = ARR_NUM_RD + ARR_NUM_WR,
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_type,
   input  logic [RA_BITS-1:0]   in_addr,
   input  logic [N-1:0]         pop,
   output logic [N-1:0]         push,
   output logic [RA_BITS-1:0]   push_addr,
   output logic [N*CNT_W-1:0]   occ,
   output logic                 err
);

   localparam int IDX_W = $clog2(N);

   logic [CNT_W-1:0]   cnt_q [N];
   logic [CNT_W-1:0]   cnt_d [N];
   logic [RA_BITS-1:0] last_addr_q [N];
   logic [RA_BITS-1:0] last_addr_d [N];
   logic [N-1:0]       last_vld_q, last_vld_d;
   logic [IDX_W-1:0]   rr_rd_q, rr_rd_d;
   logic [IDX_W-1:0]   rr_wr_q, rr_wr_d;
   logic [N-1:0]       push_q, push_d;
   logic [RA_BITS-1:0] push_addr_q, push_addr_d;
   logic               err_q, err_d;

   logic               is_rd, is_wr;
   logic [N-1:0]       grp, t_hit, t_empty, t_mid, t_nf, tier;
   logic [IDX_W-1:0]   sel;
   logic               found;
   logic               accept;
   logic               inc;
   int unsigned        grp_base, grp_size, rr_ptr, idx;

   // Candidate sets per tier, restricted to the group of the incoming request type.
   always_comb begin
      is_rd = (in_type == 1'(READ));
      is_wr = (in_type == 1'(WRITE));
      grp     = '0;
      t_nf    = '0;
      t_hit   = '0;
      t_empty = '0;
      t_mid   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         grp[i]     = (i < ARR_NUM_RD) ? is_rd : is_wr;
         t_nf[i]    = grp[i] & (cnt_q[i] < CNT_W'(DEPTH));
         t_hit[i]   = t_nf[i] & last_vld_q[i] & (last_addr_q[i] == in_addr);
         t_empty[i] = grp[i] & (cnt_q[i] == '0);
         t_mid[i]   = grp[i] & (cnt_q[i] < CNT_W'(MID_LEVEL));
      end
      if (|t_hit)        tier = t_hit;
      else if (|t_empty) tier = t_empty;
      else if (|t_mid)   tier = t_mid;
      else               tier = t_nf;
   end

   // Round-robin scan of the winning tier, starting at the group pointer and wrapping at the group end.
   always_comb begin
      grp_base = is_rd ? 32'd0 : 32'(ARR_NUM_RD);
      grp_size = is_rd ? 32'(ARR_NUM_RD) : 32'(ARR_NUM_WR);
      rr_ptr   = is_rd ? 32'(rr_rd_q) : 32'(rr_wr_q);
      idx      = 0;
      found    = 1'b0;
      sel      = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (k < grp_size) begin
            idx = rr_ptr + k;
            if (idx >= grp_base + grp_size) idx = idx - grp_size;
            if (!found && tier[idx]) begin
               found = 1'b1;
               sel   = IDX_W'(idx);
            end
         end
      end
   end

   assign in_ready = ~rst & (|t_nf);
   assign accept   = in_valid & in_ready;

   always_comb begin
      rr_rd_d     = rr_rd_q;
      rr_wr_d     = rr_wr_q;
      push_d      = '0;
      push_addr_d = push_addr_q;
      err_d       = err_q;
      last_vld_d  = last_vld_q;
      inc         = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         cnt_d[i]       = cnt_q[i];
         last_addr_d[i] = last_addr_q[i];
      end
      // Accept and pop on the same array cancel; a pop on an idle empty array only flags the error.
      for (int unsigned i = 0; i < N; i++) begin
         inc = accept && (32'(sel) == i);
         if (inc && !pop[i]) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end else if (!inc && pop[i]) begin
            if (cnt_q[i] == '0) err_d = 1'b1;
            else                cnt_d[i] = cnt_q[i] - 1'b1;
         end
         if (inc) begin
            last_vld_d[i]  = 1'b1;
            last_addr_d[i] = in_addr;
         end else if (pop[i] && (cnt_q[i] == CNT_W'(1))) begin
            last_vld_d[i]  = 1'b0;
         end
      end
      if (accept) begin
         push_d[sel] = 1'b1;
         push_addr_d = in_addr;
         if (is_rd) rr_rd_d = (32'(sel) == ARR_NUM_RD - 1) ? '0 : sel + 1'b1;
         else       rr_wr_d = (32'(sel) == N - 1) ? IDX_W'(ARR_NUM_RD) : sel + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < N; i++) begin
            cnt_q[i]       <= '0;
            last_addr_q[i] <= '0;
         end
         last_vld_q  <= '0;
         rr_rd_q     <= '0;
         rr_wr_q     <= IDX_W'(ARR_NUM_RD);
         push_q      <= '0;
         push_addr_q <= '0;
         err_q       <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            cnt_q[i]       <= cnt_d[i];
            last_addr_q[i] <= last_addr_d[i];
         end
         last_vld_q  <= last_vld_d;
         rr_rd_q     <= rr_rd_d;
         rr_wr_q     <= rr_wr_d;
         push_q      <= push_d;
         push_addr_q <= push_addr_d;
         err_q       <= err_d;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_occ
      assign occ[g*CNT_W +: CNT_W] = cnt_q[g];
   end

   assign push      = push_q;
   assign push_addr = push_addr_q;
   assign err       = err_q;

endmodule

// File: tb/tb_req_array_selector.sv
// Directed bench for req_array_selector: tier priority, round-robin, backpressure, pop/err and reset.
module tb_req_array_selector;

   localparam int N  = 7;
   localparam int CW = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic              in_type;
   logic [7:0]        in_addr;
   logic [N-1:0]      pop;
   logic [N-1:0]      push;
   logic [7:0]        push_addr;
   logic [N*CW-1:0]   occ;
   logic              err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   req_array_selector #(
      .RA_BITS    (8),
      .ARR_NUM_RD (4),
      .ARR_NUM_WR (3),
      .DEPTH      (8),
      .MID_LEVEL  (4),
      .READ       (0),
      .WRITE      (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_type   (in_type),
      .in_addr   (in_addr),
      .pop       (pop),
      .push      (push),
      .push_addr (push_addr),
      .occ       (occ),
      .err       (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] occ_of(input int i);
      return 32'(occ[i*CW +: CW]);
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      // Reset with a read already presented: not ready while in reset.
      rst = 1'b1; in_valid = 1'b1; in_type = 1'b0; in_addr = 8'h12; pop = '0;
      tick();
      #1 chk("rst_in_ready", 32'(in_ready), 0);
      tick();
      chk("rst_push", 32'(push), 0);
      chk("rst_push_addr", 32'(push_addr), 0);
      chk("rst_occ", 32'(occ), 0);
      chk("rst_err", 32'(err), 0);

      // Reads: first into array 0, then a row hit, then empty arrays in round-robin order.
      rst = 1'b0;
      #1 chk("t1_ready", 32'(in_ready), 1);
      tick();
      chk("t1_push", 32'(push), 32'h01);
      chk("t1_push_addr", 32'(push_addr), 32'h12);
      chk("t1_occ0", occ_of(0), 1);
      tick();
      chk("t2_hit_push", 32'(push), 32'h01);
      chk("t2_hit_occ0", occ_of(0), 2);
      in_addr = 8'h34;
      tick();
      chk("t2_empty1_push", 32'(push), 32'h02);
      chk("t2_occ1", occ_of(1), 1);
      in_addr = 8'h56;
      tick();
      chk("t2_empty2_push", 32'(push), 32'h04);
      chk("t2_push_addr", 32'(push_addr), 32'h56);
      in_valid = 1'b0;
      tick();
      chk("idle_push", 32'(push), 0);
      chk("idle_push_addr_hold", 32'(push_addr), 32'h56);

      // Writes only touch arrays 4..6.
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0; in_valid = 1'b1; in_type = 1'b1; in_addr = 8'hAA;
      tick();
      chk("t3_wr_aa", 32'(push), 32'h10);
      in_addr = 8'hBB;
      tick();
      chk("t3_wr_bb", 32'(push), 32'h20);
      in_addr = 8'hAA;
      tick();
      chk("t3_wr_hit", 32'(push), 32'h10);
      in_valid = 1'b0;
      tick();
      chk("t3_occ_rd", 32'(occ[4*CW-1:0]), 0);
      chk("t3_occ4", occ_of(4), 2);
      chk("t3_occ5", occ_of(5), 1);
      chk("t3_occ6", occ_of(6), 0);

      // Fill all read arrays, then check backpressure and the delayed effect of a pop.
      in_valid = 1'b1; in_type = 1'b0;
      for (int k = 0; k < 32; k++) begin
         in_addr = 8'(8'h80 + k);
         #1 chk("t4_fill_ready", 32'(in_ready), 1);
         tick();
      end
      for (int i = 0; i < 4; i++) chk("t4_full_occ", occ_of(i), 8);
      in_addr = 8'hC0;
      #1 chk("t4_rd_ready_full", 32'(in_ready), 0);
      in_type = 1'b1;
      #1 chk("t4_wr_ready", 32'(in_ready), 1);
      in_type = 1'b0; pop = 7'b0000100;
      #1 chk("t4_pop_same_cycle_ready", 32'(in_ready), 0);
      tick();
      chk("t4_no_push", 32'(push), 0);
      chk("t4_occ2_popped", occ_of(2), 7);
      pop = '0;
      #1 chk("t4_ready_after_pop", 32'(in_ready), 1);
      tick();
      chk("t4_push2", 32'(push), 32'h04);
      chk("t4_push_addr", 32'(push_addr), 32'hC0);
      chk("t4_occ2_refill", occ_of(2), 8);
      in_valid = 1'b0;

      // Simultaneous accept/pop on array 3, then drain and underflow array 1.
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0; in_valid = 1'b1; in_type = 1'b0;
      in_addr = 8'h01; tick();
      in_addr = 8'h02; tick();
      in_addr = 8'h03; tick();
      in_addr = 8'h04; tick();
      chk("t5_spread_push3", 32'(push), 32'h08);
      tick(); tick();
      in_valid = 1'b0;
      tick();
      chk("t5_occ3_pre", occ_of(3), 3);
      in_valid = 1'b1; pop = 7'b0001000;
      tick();
      chk("t5_push3", 32'(push), 32'h08);
      chk("t5_occ3_same", occ_of(3), 3);
      in_valid = 1'b0; pop = 7'b0000010;
      tick();
      chk("t5_occ1_drain", occ_of(1), 0);
      chk("t5_err_clean", 32'(err), 0);
      tick();
      chk("t5_occ1_under", occ_of(1), 0);
      chk("t5_err_set", 32'(err), 1);
      pop = '0;
      tick();
      chk("t5_err_sticky", 32'(err), 1);

      // Reset right after an accept drops the pending push and clears err.
      in_valid = 1'b1; in_addr = 8'h77;
      tick();
      chk("t6_push_pending", 32'(push), 32'h02);
      rst = 1'b1;
      #1 chk("t6_rst_ready", 32'(in_ready), 0);
      tick();
      chk("t6_push_dropped", 32'(push), 0);
      chk("t6_occ", 32'(occ), 0);
      chk("t6_err", 32'(err), 0);
      rst = 1'b0; in_valid = 1'b0;
      tick();
      chk("t6_push_idle", 32'(push), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
